ps2_line_builder: RTL
=====================

// Module: ps2_line_builder
// PURPOSE
//   Producer side of the PS/2 command-line interface. Accepts decoded ASCII keystrokes
//   and assembles them into a 32-character, 256-bit edit line. The line is shown live
//   on ps2_line_content. On Enter it commits the line to the on-screen command tracker
//   with a one-cycle ps2_line_ready strobe.
//   Sits between the PS/2 scan-code-to-ASCII decoder and the command printer/tracker.
// PARAMETERS
//   MAX_CHARS       32     usable characters per line (1..32); slots >= MAX_CHARS stay 8'h00
//   ENTER_CODE      8'h0D  ASCII code that commits the line
//   BACKSPACE_CODE  8'h08  ASCII code that deletes the last character
//   COMMIT_EMPTY    0      1: Enter on an empty line still strobes ps2_line_ready
// PORTS
//   clock             in   1    single system clock, rising edge
//   reset             in   1    synchronous, active-high
//   key_valid         in   1    one-cycle strobe: key_ascii is valid this cycle
//   key_ascii         in   8    ASCII code of the key
//   ps2_line_content  out  256  char i at [255-8i -: 8]; empty slots 8'h00
//   ps2_line_ready    out  1    one-cycle commit strobe
//   line_length       out  6    characters currently in the line (0..MAX_CHARS)
//   key_dropped       out  1    one-cycle pulse: an accepted-class key was discarded
//   busy              out  1    high while in COMMIT (keys are not accepted)
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset values: content 256'h0, ready 0, line_length 0, key_dropped 0, busy 0, state EDIT.
//   - FSM states: EDIT, COMMIT.
//   - EDIT, key_valid=1, decoded on the edge where it is sampled; result visible the next cycle:
//       * printable (8'h20..8'h7E):
//           - length < MAX_CHARS: write to slot[length], length += 1
//           - otherwise: no change, key_dropped=1
//       * BACKSPACE_CODE:
//           - length > 0: slot[length-1] <= 8'h00, length -= 1
//           - length == 0: ignored, no dropped pulse
//       * ENTER_CODE:
//           - length > 0 or COMMIT_EMPTY=1: go to COMMIT; ready=1 and busy=1 on the next cycle
//           - else: ignored
//       * any other code: ignored, no dropped pulse
//   - COMMIT lasts exactly one cycle:
//       * ps2_line_ready=1 and content holds the committed line, unchanged
//       * next edge: content <= 0, length <= 0, ready <= 0, busy <= 0, state <= EDIT
//   - key_valid during COMMIT: key discarded, key_dropped=1 on the following cycle.
//     No buffering of keys.
//   - Enter and ready: Enter sampled at edge N -> ready high during cycle N+1 only.
//     The minimum spacing between two ready strobes is 2 cycles.
//   - key_valid is a strobe: back-to-back keys on consecutive cycles are each processed.
//   - Simultaneous reset and key_valid: reset wins and the key is lost.
//   - Reset mid-line or in COMMIT: line cleared next cycle, and any pending ready is suppressed.
//   - line_length never exceeds MAX_CHARS and never wraps below 0.
//   - ps2_line_ready is never held for more than one cycle.
// TESTING
//   1. Reset, then keys 'L'(4C), 'S'(53), Enter.
//      -> content[255:240]=16'h4C53, rest 0; ready high exactly 1 cycle;
//         length 2 during ready, 0 after; content 0 after.
//   2. 33 x 'A'(41), back-to-back.
//      -> all 32 slots = 8'h41; length=32; a single key_dropped pulse on the 33rd key.
//   3. 'A', 'B', Backspace, Backspace, Backspace.
//      -> length 2->1->0->0; content 0; no key_dropped.
//   4. Enter on an empty line.
//      -> COMMIT_EMPTY=0: no ready.
//      -> COMMIT_EMPTY=1: ready pulse with content 0.
//   5. 'X', Enter, then 'Y' on the very next cycle (during COMMIT).
//      -> ready with slot0=8'h58; 'Y' dropped with key_dropped=1; line empty afterwards.
//   6. 'Q','R', then reset for 1 cycle together with key_valid 'Z'.
//      -> content 0, length 0, no ready.
//      -> A following 'Z' lands in slot0.

Source files
------------

// File: rtl/ps2_line_builder.sv
// Assembles decoded ASCII keystrokes into a 32-slot, 256-bit edit line and commits it on Enter.
// Latency: one cycle from a sampled key to the updated line; ready strobes the cycle after Enter.
// Backpressure: none; keys arriving during the one-cycle commit are discarded and flagged on key_dropped.
module ps2_line_builder #(
    parameter int           MAX_CHARS      = 32,
    parameter logic [7:0]   ENTER_CODE     = 8'h0D,
    parameter logic [7:0]   BACKSPACE_CODE = 8'h08,
    parameter bit           COMMIT_EMPTY   = 1'b0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           key_valid,
    input  logic [7:0]     key_ascii,
    output logic [255:0]   ps2_line_content,
    output logic           ps2_line_ready,
    output logic [5:0]     line_length,
    output logic           key_dropped,
    output logic           busy
);

    typedef enum logic {
        EDIT   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    // Length limit in the same width as line_length so comparisons stay width-exact.
    localparam logic [5:0] MAX_LEN = 6'(MAX_CHARS);

    state_t state;
    logic   key_printable;

    // Printable ASCII range is space through tilde; DEL and control codes are not stored.
    assign key_printable = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);

    // Line editing FSM: EDIT accepts keys, COMMIT holds the finished line for exactly one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= EDIT;
            ps2_line_content <= '0;
            ps2_line_ready   <= 1'b0;
            line_length      <= '0;
            key_dropped      <= 1'b0;
            busy             <= 1'b0;
        end else begin
            key_dropped <= 1'b0;
            case (state)
                EDIT: begin
                    if (key_valid) begin
                        if (key_ascii == ENTER_CODE) begin
                            // An empty line only commits when explicitly allowed.
                            if ((line_length != 6'd0) || COMMIT_EMPTY) begin
                                state          <= COMMIT;
                                ps2_line_ready <= 1'b1;
                                busy           <= 1'b1;
                            end
                        end else if (key_ascii == BACKSPACE_CODE) begin
                            // Backspace on an empty line is silently ignored.
                            if (line_length != 6'd0) begin
                                for (int i = 0; i < 32; i++) begin
                                    if (6'(i) == line_length - 6'd1) begin
                                        ps2_line_content[255 - 8*i -: 8] <= 8'h00;
                                    end
                                end
                                line_length <= line_length - 6'd1;
                            end
                        end else if (key_printable) begin
                            if (line_length < MAX_LEN) begin
                                // Slots at or beyond MAX_CHARS are never written and stay zero.
                                for (int i = 0; i < 32; i++) begin
                                    if ((i < MAX_CHARS) && (6'(i) == line_length)) begin
                                        ps2_line_content[255 - 8*i -: 8] <= key_ascii;
                                    end
                                end
                                line_length <= line_length + 6'd1;
                            end else begin
                                key_dropped <= 1'b1;
                            end
                        end
                    end
                end
                COMMIT: begin
                    // The consumer has seen the line during the ready cycle; start a fresh one.
                    state            <= EDIT;
                    ps2_line_content <= '0;
                    line_length      <= '0;
                    ps2_line_ready   <= 1'b0;
                    busy             <= 1'b0;
                    if (key_valid) begin
                        key_dropped <= 1'b1;
                    end
                end
                default: begin
                    state <= EDIT;
                end
            endcase
        end
    end

endmodule
